boom_sequencer: RTL and testbench
=================================

// Module: boom_sequencer
// PURPOSE
//  Sequencer for the "boom" divisible-by-N game datapath. Walks a count 1..MAX_COUNT
//  at a prescaled tick rate and flags every multiple of DIVISOR as a "boom".
//  On a boom it freezes the count, shows all-ones on the display and lights the LED
//  for HOLD_TICKS ticks before resuming. Sits between the board buttons and the
//  7-seg decoder / LED outputs.
// PARAMETERS
//  WIDTH      5   count / display width in bits
//  DIVISOR    6   boom when count % DIVISOR == 0
//  MAX_COUNT  31  last count value; must be <= 2**WIDTH-1
//  TICK_DIV   25_000_000  clk cycles per tick (>=2); bench uses 4
//  HOLD_TICKS 2   ticks the boom pattern is held (>=1)
// PORTS
//  clk        in   1      system clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      level; begins a run from IDLE or DONE
//  stop       in   1      level; aborts to IDLE from any state
//  count_out  out  WIDTH  current count value, raw
//  disp_out   out  WIDTH  display value: count_out, or all-ones during boom hold
//  boom_led   out  1      high during boom hold
//  busy       out  1      high in RUN or HOLD
//  done       out  1      high in DONE
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  Reset: state=IDLE, count_out=0, disp_out=0, boom_led=0, busy=0, done=0,
//   prescaler=0, hold counter=0. All outputs are registered.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN/HOLD. It emits a 1-cycle tick on
//   the wrap. It is cleared on entry to RUN from IDLE/DONE, not on HOLD->RUN.
//  FSM states: IDLE, RUN, HOLD, DONE.
//   IDLE: start & !stop -> RUN. count_out<=1, disp_out<=1, prescaler<=0.
//   RUN, on tick:
//    count==MAX_COUNT -> DONE. count holds.
//    else next=count+1. If next%DIVISOR==0 -> HOLD: count<=next,
//     disp<=all-ones, boom_led<=1, hold_cnt<=HOLD_TICKS-1.
//    else count<=next, disp<=next.
//   HOLD, on tick:
//    hold_cnt==0 -> RUN. boom_led<=0, disp<=count. Count advances on the next RUN tick.
//    else hold_cnt-1.
//   DONE: outputs frozen, done=1. start & !stop -> RUN (restart at 1, as IDLE).
//   Any state: stop=1 -> IDLE next cycle. count/disp/led/hold/prescaler all cleared.
//  Priority: rst > stop > start > tick. start while RUN/HOLD is ignored.
//  Latency: outputs change on the cycle after the tick. The boom is visible on the
//   same edge as the boomed count value. There is no one-cycle gap showing the raw value.
//  Boundaries:
//   - MAX_COUNT itself a multiple of DIVISOR: enter HOLD, then on the expiry tick go
//     RUN. The next RUN tick goes to DONE.
//   - count 0 never appears while busy, so it is never a boom.
//   - Modulo is evaluated on the WIDTH-bit unsigned next value. No wrap past MAX_COUNT.
//   - stop during HOLD drops boom_led on the following cycle.
// STRUCTURE
//  Shared package/header (boom_pkg): FSM state encodings (2-bit), default
//   WIDTH/DIVISOR constants, all-ones BOOM_PATTERN.
//  Sub-module boom_mod_check(WIDTH,DIVISOR): combinational, value -> is_boom.
//   Instantiated once on the next-count value. It replaces the standalone comparator
//   in the top level.
//  Prescaler, hold counter and FSM live in this module.
// TESTING (TICK_DIV=4, HOLD_TICKS=2, defaults otherwise)
//  1. rst high 3 cycles, then low -> all outputs 0, busy=0, done=0. start ignored while rst high.
//  2. start pulse from IDLE -> count_out=1 next cycle, busy=1. Count 2,3,4,5 follow
//     at 4-cycle spacing.
//  3. Reaching 6 -> disp_out=5'b11111, boom_led=1 for exactly 8 cycles,
//     count_out=6. Then disp_out=6, led=0. 7 appears 4 cycles later.
//  4. Full run to 31 -> booms at 6,12,18,24,30. done=1, busy=0 one tick after 31.
//     start then restarts at 1.
//  5. stop asserted mid-HOLD at count 12 -> next cycle IDLE, count_out=0, boom_led=0.
//     start & stop together -> stays IDLE.
//  6. rst asserted mid-RUN at count 9 -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/boom_pkg.sv
// Shared constants for the boom sequencer: FSM encodings, default sizes and the
// display pattern shown while a boom is held.
package boom_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int DEF_WIDTH   = 5;
  localparam int DEF_DIVISOR = 6;

  // Wide all-ones source; users truncate it to their own display width.
  localparam logic [31:0] BOOM_PATTERN = '1;

endpackage

// File: rtl/boom_mod_check.sv
// Combinational divisibility test: flags a value that is an exact multiple of DIVISOR.
module boom_mod_check #(
  parameter int WIDTH   = 5,
  parameter int DIVISOR = 6
) (
  input  logic [WIDTH-1:0] value,
  output logic             is_boom
);

  localparam logic [WIDTH-1:0] DIV_W = WIDTH'(DIVISOR);

  assign is_boom = ((value % DIV_W) == '0);

endmodule

// File: rtl/boom_sequencer.sv
// Boom game sequencer: walks 1..MAX_COUNT on a prescaled tick, freezing on every
// multiple of DIVISOR with the display forced to all-ones for HOLD_TICKS ticks.
module boom_sequencer
  import boom_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DIVISOR    = DEF_DIVISOR,
  parameter int MAX_COUNT  = 31,
  parameter int TICK_DIV   = 25_000_000,
  parameter int HOLD_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] disp_out,
  output logic             boom_led,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0]    HOLD_INIT  = HW'(HOLD_TICKS - 1);
  localparam logic [WIDTH-1:0] LAST_CNT   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] FIRST_CNT  = WIDTH'(1);
  localparam logic [WIDTH-1:0] BOOM_DISP  = WIDTH'(BOOM_PATTERN);

  state_t           state;
  logic [PW-1:0]    presc;
  logic [HW-1:0]    hold_cnt;
  logic             tick;
  logic [WIDTH-1:0] next_count;
  logic             next_is_boom;

  assign tick       = (presc == PRESC_LAST);
  assign next_count = count_out + WIDTH'(1);

  // The boom decision is made on the value about to be shown, so the pattern
  // appears on the very edge that loads the boomed count.
  boom_mod_check #(
    .WIDTH   (WIDTH),
    .DIVISOR (DIVISOR)
  ) u_mod_check (
    .value   (next_count),
    .is_boom (next_is_boom)
  );

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      state     <= ST_IDLE;
      presc     <= '0;
      hold_cnt  <= '0;
      count_out <= '0;
      disp_out  <= '0;
      boom_led  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            presc     <= '0;
            hold_cnt  <= '0;
            count_out <= FIRST_CNT;
            disp_out  <= FIRST_CNT;
            boom_led  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        ST_RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (count_out == LAST_CNT) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (next_is_boom) begin
              state     <= ST_HOLD;
              count_out <= next_count;
              disp_out  <= BOOM_DISP;
              boom_led  <= 1'b1;
              hold_cnt  <= HOLD_INIT;
            end else begin
              count_out <= next_count;
              disp_out  <= next_count;
            end
          end
        end

        ST_HOLD: begin
          // Prescaler keeps running through the hold so the resume is tick-aligned.
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (hold_cnt == '0) begin
              state    <= ST_RUN;
              boom_led <= 1'b0;
              disp_out <= count_out;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boom_sequencer.sv
// Scoreboard bench for boom_sequencer: a timeline model of one uninterrupted run
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_boom_sequencer;

  localparam int W    = 5;
  localparam int DIV  = 6;
  localparam int MAXC = 31;
  localparam int TD   = 4;
  localparam int HT   = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] count_out;
  logic [W-1:0] disp_out;
  logic         boom_led;
  logic         busy;
  logic         done;

  boom_sequencer #(
    .WIDTH      (W),
    .DIVISOR    (DIV),
    .MAX_COUNT  (MAXC),
    .TICK_DIV   (TD),
    .HOLD_TICKS (HT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .count_out (count_out),
    .disp_out  (disp_out),
    .boom_led  (boom_led),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic [W-1:0] disp;
    logic         led;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t timeline[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Model state: position inside the run timeline, or idle / finished.
  bit active = 0;
  bit finished = 0;
  int idx = 0;

  task automatic build_timeline();
    exp_t e;
    logic [W-1:0] cv;
    for (int c = 1; c <= MAXC; c++) begin
      cv = W'(c);
      if (c % DIV == 0) begin
        e = '{count: cv, disp: {W{1'b1}}, led: 1'b1, busy: 1'b1, done: 1'b0};
        repeat (HT * TD) timeline.push_back(e);
      end
      e = '{count: cv, disp: cv, led: 1'b0, busy: 1'b1, done: 1'b0};
      repeat (TD) timeline.push_back(e);
    end
  endtask

  function automatic exp_t expected_now();
    exp_t e;
    if (active)
      e = timeline[idx];
    else if (finished)
      e = '{count: W'(MAXC), disp: W'(MAXC), led: 1'b0, busy: 1'b0, done: 1'b1};
    else
      e = '0;
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit p);
    if (r || p) begin
      active   = 0;
      finished = 0;
    end else if (!active && s) begin
      active   = 1;
      finished = 0;
      idx      = 0;
    end else if (active) begin
      idx++;
      if (idx >= timeline.size()) begin
        active   = 0;
        finished = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p);
    rst   = r;
    start = s;
    stop  = p;
    @(posedge clk);
    model_edge(r, s, p);
    sb.push_back(expected_now());
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    cyc++;
    if (sb.size() > 0) begin
      want = sb.pop_front();
      got  = '{count: count_out, disp: disp_out, led: boom_led, busy: busy, done: done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs@cyc%0d: got count=%0d disp=%0d led=%0b busy=%0b done=%0b, want count=%0d disp=%0d led=%0b busy=%0b done=%0b",
                 cyc, got.count, got.disp, got.led, got.busy, got.done,
                 want.count, want.disp, want.led, want.busy, want.done);
      end
    end
  end

  task automatic run_until(input int cnt, input bit led, input int budget);
    int n = 0;
    while (!(active && timeline[idx].count == W'(cnt) && timeline[idx].led == led)) begin
      if (n >= budget) begin
        errors++;
        checks++;
        $display("FAIL run_until: count %0d led %0b not reached in %0d cycles", cnt, led, budget);
        return;
      end
      step(0, 0, 0);
      n++;
    end
  endtask

  initial begin
    bit r, s, p;
    build_timeline();
    @(negedge clk);
    #1;

    // Reset held with start asserted: start must be ignored.
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    // Full run to DONE, a few cycles parked, then restart.
    step(0, 1, 0);
    repeat (timeline.size() + 5) step(0, 0, 0);
    step(0, 1, 0);

    // Stop in the middle of the boom hold at 12, then start with stop together.
    run_until(12, 1, 400);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 1, 1);
    repeat (3) step(0, 0, 0);

    // Reset in the middle of a run at 9.
    step(0, 1, 0);
    run_until(9, 0, 400);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);

    // Random control traffic, including start during RUN/HOLD and stop in DONE.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 599) == 0);
      p = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 19) == 0);
      step(r, s, p);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
